// File: rtl/vscale_hasti_sram_slave.sv
// Point-to-point AHB-Lite (HASTI) SRAM responder: register-based word memory,
// programmable OKAY wait states and two-cycle ERROR response.
module vscale_hasti_sram_slave #(
  parameter int unsigned WORDS       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam int unsigned AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [32:0] BYTES     = 33'(WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic [31:0]   addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [31:0]   mem [WORDS];

  logic          accept;
  logic          xfer_err;
  logic          mem_we;
  logic [3:0]    be;
  logic [AW-1:0] widx;

  logic          unused_inputs;
  assign unused_inputs = ^{hburst, hmastlock, hprot, htrans[0], addr_q[31:AW+2]};

  assign widx   = addr_q[AW+1:2];
  assign mem_we = (state == S_DATA) && (cnt == '0) && write_q;

  always_comb begin
    xfer_err = 1'b0;
    if (hsize > 3'd2)                           xfer_err = 1'b1;
    if ((hsize == 3'd1) && haddr[0])            xfer_err = 1'b1;
    if ((hsize == 3'd2) && (haddr[1:0] != '0))  xfer_err = 1'b1;
    if ({1'b0, haddr} >= BYTES)                 xfer_err = 1'b1;
  end

  // hready doubles as the address-phase qualifier, so acceptance and the
  // next state are resolved after the current phase's hready is known.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hready     = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_DATA: begin
        hready = (cnt == '0);
        if (!write_q) hrdata = mem[widx];
        if (cnt != '0) cnt_next = cnt - 4'd1;
      end
      S_ERR1: begin
        hready     = 1'b0;
        hresp      = 1'b1;
        state_next = S_ERR2;
      end
      S_ERR2: hresp = 1'b1;
    endcase
    if (hready) begin
      accept = htrans[1];
      if (!accept) begin
        state_next = S_IDLE;
      end else if (xfer_err) begin
        state_next = S_ERR1;
      end else begin
        state_next = S_DATA;
        cnt_next   = WAIT_INIT;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  always_comb begin
    unique case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = '1;
    endcase
  end

  // No reset on the array; an asserted reset drops state to IDLE, which
  // disables mem_we and discards any pending write.
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Directed bench for vscale_hasti_sram_slave: three instances (0, 2, 3 wait
// states), pipelined AHB beats, expected data phases held in a scoreboard queue.
module tb_vscale_hasti_sram_slave;

  localparam int N = 3;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr  [N];
  logic [31:0] hwdata [N];
  logic [31:0] hrdata [N];
  logic        hwrite [N];
  logic        hready [N];
  logic        hresp  [N];
  logic [2:0]  hsize  [N];
  logic [1:0]  htrans [N];

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       tag;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    vscale_hasti_sram_slave #(
      .WORDS       (1024),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) dut (
      .hclk      (clk),
      .hresetn   (hresetn),
      .haddr     (haddr[g]),
      .hwrite    (hwrite[g]),
      .hsize     (hsize[g]),
      .hburst    (3'b010),
      .hmastlock (1'b0),
      .hprot     (4'b0011),
      .htrans    (htrans[g]),
      .hwdata    (hwdata[g]),
      .hrdata    (hrdata[g]),
      .hready    (hready[g]),
      .hresp     (hresp[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input int k, input string tag, input logic rdy,
                         input logic rsp, input logic [31:0] rd);
    chk({tag, "/hready"}, 32'(hready[k]), 32'(rdy));
    chk({tag, "/hresp"},  32'(hresp[k]),  32'(rsp));
    chk({tag, "/hrdata"}, hrdata[k], rd);
  endtask

  // One bus beat, entered at a falling edge: presents a new address phase,
  // drives hwdata for the data phase in flight, checks that phase every
  // cycle until hready, then queues the new transfer's expectation.
  task automatic beat(input int k, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input logic er, input string tag);
    exp_t cur;
    bit   pend;
    int   n;
    pend        = (sb.size() > 0);
    htrans[k]   = tr;
    hwrite[k]   = wr;
    haddr[k]    = a;
    hsize[k]    = sz;
    hwdata[k]   = 32'hFFFF_FFFF;
    if (pend) begin
      cur = sb[0];
      if (cur.wr) hwdata[k] = cur.wdata;
    end
    #1;
    if (!pend) begin
      chk_out(k, {tag, "/idle"}, 1'b1, 1'b0, 32'h0);
    end else begin
      n = 0;
      forever begin
        chk({cur.tag, "/hresp"}, 32'(hresp[k]), 32'(cur.err));
        chk({cur.tag, "/hrdata"}, hrdata[k], (cur.wr || cur.err) ? 32'h0 : cur.rdata);
        if (hready[k]) break;
        n++;
        if (n > 40) begin
          checks++;
          $error("FAIL %s/timeout: observed hready=0 for %0d cycles expected at most %0d",
                 cur.tag, n, ws(k));
          break;
        end
        @(negedge clk);
        #1;
      end
      chk({cur.tag, "/waits"}, 32'(n), 32'(cur.err ? 1 : ws(k)));
      void'(sb.pop_front());
    end
    if (tr[1]) sb.push_back('{tag, wr, wd, rd, er});
    @(negedge clk);
  endtask

  initial begin
    hresetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      haddr[i]  = '0;
      hwdata[i] = '0;
      hwrite[i] = 1'b0;
      hsize[i]  = '0;
      htrans[i] = T_IDLE;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) chk_out(i, $sformatf("reset%0d", i), 1'b1, 1'b0, 32'h0);
    hresetn = 1'b1;

    // zero-wait instance: first transfer on the first edge after reset
    beat(0, T_NSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, "w10");
    beat(0, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, "r10");
    beat(0, T_NSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344, 32'h0, 1'b0, "w20");
    beat(0, T_NSEQ, 1'b1, 32'h21, 3'd0, 32'h0000AA00, 32'h0, 1'b0, "wb21");
    beat(0, T_NSEQ, 1'b0, 32'h20, 3'd2, 32'h0, 32'h1122AA44, 1'b0, "r20a");
    beat(0, T_NSEQ, 1'b1, 32'h22, 3'd1, 32'hBBBB0000, 32'h0, 1'b0, "wh22");
    beat(0, T_NSEQ, 1'b0, 32'h20, 3'd2, 32'h0, 32'hBBBBAA44, 1'b0, "r20b");
    beat(0, T_SEQ,  1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, "r10b");

    // error responses, back-to-back accept in ERR2, memory untouched
    beat(0, T_NSEQ, 1'b1, 32'h4,    3'd2, 32'h55667788, 32'h0, 1'b0, "w04");
    beat(0, T_NSEQ, 1'b0, 32'h6,    3'd2, 32'h0, 32'h0, 1'b1, "e06");
    beat(0, T_NSEQ, 1'b0, 32'h1000, 3'd2, 32'h0, 32'h0, 1'b1, "e1000");
    beat(0, T_NSEQ, 1'b1, 32'h8,    3'd2, 32'h00001234, 32'h0, 1'b0, "w08");
    beat(0, T_NSEQ, 1'b1, 32'h6,    3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, "ew06");
    beat(0, T_NSEQ, 1'b1, 32'h5,    3'd1, 32'hFFFFFFFF, 32'h0, 1'b1, "ewh05");
    beat(0, T_NSEQ, 1'b1, 32'h4,    3'd3, 32'hFFFFFFFF, 32'h0, 1'b1, "esz3");
    beat(0, T_NSEQ, 1'b0, 32'h4,    3'd2, 32'h0, 32'h55667788, 1'b0, "r04");
    beat(0, T_NSEQ, 1'b0, 32'h8,    3'd2, 32'h0, 32'h00001234, 1'b0, "r08a");

    // IDLE and BUSY with hwrite set must not start a data phase
    beat(0, T_IDLE, 1'b1, 32'h8, 3'd2, 32'h0, 32'h0, 1'b0, "idle08");
    beat(0, T_BUSY, 1'b1, 32'h8, 3'd2, 32'h0, 32'h0, 1'b0, "busy08");
    beat(0, T_NSEQ, 1'b0, 32'h8, 3'd2, 32'h0, 32'h00001234, 1'b0, "r08b");
    beat(0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, "drain0");

    // two-wait instance
    beat(1, T_NSEQ, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, "w2_00");
    beat(1, T_NSEQ, 1'b0, 32'h0, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, "r2_00");
    beat(1, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, "drain1");

    // three-wait instance: reset in the middle of a write phase
    beat(2, T_NSEQ, 1'b1, 32'h40, 3'd2, 32'h0, 32'h0, 1'b0, "w3_40");
    beat(2, T_NSEQ, 1'b0, 32'h40, 3'd2, 32'h0, 32'h0, 1'b0, "r3_40a");
    beat(2, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, "drain2");
    htrans[2] = T_NSEQ;
    hwrite[2] = 1'b1;
    haddr[2]  = 32'h40;
    hsize[2]  = 3'd2;
    @(negedge clk);
    htrans[2] = T_IDLE;
    hwdata[2] = 32'h12345678;
    #1;
    chk("rst_mid/hready_low", 32'(hready[2]), 32'h0);
    #1 hresetn = 1'b0;
    #1;
    chk_out(2, "rst_async", 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    hresetn = 1'b1;
    beat(2, T_NSEQ, 1'b0, 32'h40, 3'd2, 32'h0, 32'h0, 1'b0, "r3_40b");
    beat(2, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, "drain3");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_sram_slave.md
VSCALE_HASTI_SRAM_SLAVE -- requirements
Module: vscale_hasti_sram_slave

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WORDS, 1024, number of 32-bit memory words; valid byte address range is 0 .. WORDS*4-1.
  WAIT_STATES, 0, hready-low cycles inserted in every OKAY data phase; legal range 0..15.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  hclk  in  1  sole clock; all state changes on rising edge.
  hresetn  in  1  reset, asynchronous assert, active-low.
  haddr  in  32  address-phase byte address.
  hwrite  in  1  address-phase write flag.
  hsize  in  3  address-phase size: 0 = byte, 1 = half, 2 = word.
  hburst  in  3  ignored; every transfer is treated as single.
  hmastlock  in  1  ignored.
  hprot  in  4  ignored.
  htrans  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
  hwdata  in  32  data-phase write data, byte lanes by address.
  hrdata  out  32  data-phase read data.
  hready  out  1  1 = current data phase completes this cycle.
  hresp  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-003 The block SHALL be a point-to-point AHB-Lite (HASTI) responder with no hsel; its hready is also the address-phase qualifier.
REQ-004 An address phase SHALL be accepted on a rising edge where hready=1 and htrans is NONSEQ or SEQ; the block then latches haddr, hwrite and hsize.
REQ-005 On a rising edge where hready=1 and htrans is IDLE or BUSY, the block SHALL start no data phase; it SHALL respond hready=1 and hresp=0.
REQ-006 A transfer SHALL be an error if any of the following holds: hsize>2; hsize=1 with haddr[0]=1; hsize=2 with haddr[1:0]!=0; haddr>=WORDS*4.
REQ-007 The FSM SHALL have four states: IDLE, DATA, ERR1, ERR2.
REQ-008 IDLE: hready=1, hresp=0, hrdata=0.
REQ-009 FSM transitions SHALL be:
  - accept with no error -> DATA, with wait counter loaded to WAIT_STATES;
  - accept with error -> ERR1;
  - no accept -> IDLE.
REQ-010 DATA with counter>0: hready=0, hresp=0; the counter decrements each cycle.
REQ-011 DATA with counter=0: hready=1, hresp=0; the phase completes at this edge, and the next state follows REQ-009 from the concurrent address phase.
REQ-012 ERR1: hready=0, hresp=1; no memory access; next state is always ERR2.
REQ-013 ERR2: hready=1, hresp=1; next state follows REQ-009, so back-to-back accept is allowed.
REQ-014 Address-phase inputs SHALL be ignored while hready=0.
REQ-015 Writes: memory SHALL update only at the completing edge of a DATA write phase (hready=1), sampling hwdata at that edge.
REQ-016 Write byte enables SHALL be:
  - byte: lane haddr[1:0];
  - half: lanes {haddr[1],0} and {haddr[1],1};
  - word: all four lanes.
  Unselected bytes are unchanged.
REQ-017 Reads: in DATA read phases, hrdata SHALL be the full 32-bit word at the latched word address (haddr[31:2]) for every cycle of the phase; the master extracts lanes.
REQ-018 hrdata SHALL be 0 in IDLE, ERR1, ERR2 and DATA write phases.
REQ-019 Read-after-write to the same word in consecutive transfers SHALL return the newly written data, with no extra wait state.
REQ-020 The memory array SHALL be register-based, with combinational read of the latched address.
REQ-021 The wait counter SHALL be 4 bits wide; WAIT_STATES=0 SHALL give zero-wait OKAY transfers (one cycle per data phase).

Reset
REQ-022 hresetn=0 SHALL immediately force: FSM to IDLE; counter to 0; latched address, write flag and size to 0; outputs hready=1, hresp=0, hrdata=0.
REQ-023 Reset asserted mid data phase SHALL discard the pending write, leaving memory unchanged.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 The first address phase SHALL be accepted on the first rising edge after hresetn deasserts.

Verification
REQ-026 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> hrdata=0xDEADBEEF, each data phase one cycle, hresp=0.
REQ-027 Word 0x11223344 @0x20, then byte write hwdata=0x0000AA00 @0x21, then read @0x20 -> 0x1122AA44; half write 0xBBBB0000 @0x22, then read -> 0xBBBBAA44.
REQ-028 WAIT_STATES=2: read @0x0 -> hready low exactly 2 cycles then high 1 cycle; hrdata valid throughout.
REQ-029 Word read @0x6 (misaligned) and @WORDS*4 (out of range) -> hready=0/hresp=1, then hready=1/hresp=1; next NONSEQ write in ERR2 completes OKAY; memory unchanged by the errored transfer.
REQ-030 Reset pulsed during a 3-wait write to 0x40 (old 0x0) -> outputs 1/0/0 asynchronously; 0x40 still reads 0x0 after reset.
REQ-031 htrans=IDLE and BUSY with hwrite=1 @0x8 -> hready stays 1, no memory change.
